// File: rtl/rib_xbar.sv
// rib_xbar: shared-bus crossbar connecting NUM_M request/ack masters to NUM_S
// slaves through a single granted path. A two-state FSM (IDLE/ACCESS) picks one
// master (fixed priority or round-robin), decodes the slave from the top
// address nibble, and completes on slave ack, timeout or unmapped-slave error.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   m_addr_i/m_data_i/m_we_i/m_req_i   packed master requests (master 0 in LSBs)
//   m_data_o/m_ack_o                    per-master read data and completion pulse
//   s_addr_o/s_data_o                   granted address (select field zeroed) / write data
//   s_we_o/s_req_o                      one-hot per-slave write enable / request
//   s_data_i/s_ack_i                    slave read data / acks (same-cycle acks legal)
//   hold_flag_o                         pipeline hold to the core
//   err_o                               error pulse (timeout or unmapped slave)
module rib_xbar #(
    parameter int unsigned NUM_M    = 4,
    parameter int unsigned NUM_S    = 8,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_M*AW-1:0] m_addr_i,
    input  logic [NUM_M*DW-1:0] m_data_i,
    input  logic [NUM_M-1:0]    m_we_i,
    input  logic [NUM_M-1:0]    m_req_i,
    output logic [NUM_M*DW-1:0] m_data_o,
    output logic [NUM_M-1:0]    m_ack_o,
    output logic [AW-1:0]       s_addr_o,
    output logic [DW-1:0]       s_data_o,
    output logic [NUM_S-1:0]    s_we_o,
    output logic [NUM_S-1:0]    s_req_o,
    input  logic [NUM_S*DW-1:0] s_data_i,
    input  logic [NUM_S-1:0]    s_ack_i,
    output logic                hold_flag_o,
    output logic                err_o
);
    localparam int unsigned MW = $clog2(NUM_M);
    localparam int unsigned SW = 4;
    localparam logic [7:0]  TCNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [MW-1:0] g_q, g_d;
    logic [MW-1:0] rr_q, rr_d;
    logic [7:0]    tcnt_q, tcnt_d;

    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic          g_we;
    logic          g_req;
    logic [SW-1:0] s_idx;
    logic          s_mapped;
    logic [NUM_S-1:0] s_sel;
    logic          s_ack;
    logic [DW-1:0] s_rdata;
    logic [MW-1:0] winner;
    logic [MW-1:0] rr_idx;
    logic [MW-1:0] g_inc;
    logic          ack_c;
    logic          err_c;
    logic          done_c;

    // Select the granted master's request fields.
    always_comb begin
        g_addr  = '0;
        g_wdata = '0;
        g_we    = 1'b0;
        g_req   = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (MW'(i) == g_q) begin
                g_addr  = m_addr_i[i*AW +: AW];
                g_wdata = m_data_i[i*DW +: DW];
                g_we    = m_we_i[i];
                g_req   = m_req_i[i];
            end
        end
    end

    // Decode the target slave; an out-of-range index leaves s_sel all-zero.
    assign s_idx    = g_addr[AW-1 -: SW];
    assign s_mapped = (32'(s_idx) < NUM_S);

    always_comb begin
        s_sel   = '0;
        s_ack   = 1'b0;
        s_rdata = '0;
        for (int j = 0; j < NUM_S; j++) begin
            if (SW'(j) == s_idx) begin
                s_sel[j] = 1'b1;
                s_ack    = s_ack_i[j];
                s_rdata  = s_data_i[j*DW +: DW];
            end
        end
    end

    // Arbiter: scan from the highest candidate down so the first hit in
    // search order is the one left standing.
    always_comb begin
        winner = '0;
        rr_idx = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            if (ARB_MODE == 0) begin
                rr_idx = MW'(k);
            end else begin
                rr_idx = MW'((32'(rr_q) + 32'(k)) % NUM_M);
            end
            if (m_req_i[rr_idx]) begin
                winner = rr_idx;
            end
        end
    end

    assign g_inc = (g_q == MW'(NUM_M - 1)) ? '0 : g_q + MW'(1);

    // Next-state and combinational outputs.
    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        rr_d        = rr_q;
        tcnt_d      = tcnt_q;
        ack_c       = 1'b0;
        err_c       = 1'b0;
        done_c      = 1'b0;
        m_ack_o     = '0;
        m_data_o    = '0;
        s_req_o     = '0;
        s_we_o      = '0;
        err_o       = 1'b0;
        hold_flag_o = 1'b0;
        s_addr_o    = g_addr;
        s_addr_o[AW-1 -: SW] = '0;
        s_data_o    = g_wdata;

        unique case (state_q)
            IDLE: begin
                hold_flag_o = |m_req_i[NUM_M-1:1];
                if (|m_req_i) begin
                    state_d = ACCESS;
                    g_d     = winner;
                    tcnt_d  = '0;
                end
            end
            ACCESS: begin
                hold_flag_o = (g_q != '0);
                s_req_o     = s_sel;
                s_we_o      = g_we ? s_sel : '0;
                // A withdrawn request wins over any ack or error this cycle.
                if (!g_req) begin
                    done_c = 1'b1;
                end else if (!s_mapped) begin
                    ack_c  = 1'b1;
                    err_c  = 1'b1;
                    done_c = 1'b1;
                end else if (s_ack) begin
                    ack_c  = 1'b1;
                    done_c = 1'b1;
                end else if (tcnt_q == TCNT_LAST) begin
                    ack_c  = 1'b1;
                    err_c  = 1'b1;
                    done_c = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
                if (done_c) begin
                    state_d = IDLE;
                    if (ARB_MODE != 0) begin
                        rr_d = g_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        for (int i = 0; i < NUM_M; i++) begin
            if (ack_c && (MW'(i) == g_q)) begin
                m_ack_o[i]           = 1'b1;
                m_data_o[i*DW +: DW] = err_c ? '0 : s_rdata;
            end
        end
        err_o = err_c;

        // Reset masks every handshake output, even mid-access.
        if (rst) begin
            m_ack_o     = '0;
            m_data_o    = '0;
            s_req_o     = '0;
            s_we_o      = '0;
            err_o       = 1'b0;
            hold_flag_o = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            rr_q    <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            rr_q    <= rr_d;
            tcnt_q  <= tcnt_d;
        end
    end

endmodule

// File: doc/rib_xbar.md
RIB_XBAR -- requirements
Module: rib_xbar

Interface
REQ-001 SHALL have parameter NUM_M, default 4: number of masters (2..8).
REQ-002 SHALL have parameter NUM_S, default 8: number of slaves (2..16).
REQ-003 SHALL have parameter AW, default 32: address width.
REQ-004 SHALL have parameter DW, default 32: data width.
REQ-005 SHALL have parameter ARB_MODE, default 0: arbitration mode, 0 = fixed priority, 1 = round-robin.
REQ-006 SHALL have parameter TIMEOUT, default 16: number of ACCESS cycles allowed without a slave ack (2..255).
REQ-007 SHALL use one clock; reset is synchronous and active-high (ports clk, rst).
REQ-008 SHALL have port clk  input  1  clock.
REQ-009 SHALL have port rst  input  1  synchronous active-high reset.
REQ-010 SHALL have port m_addr_i  input  NUM_M*AW  master addresses, packed with master 0 in the LSBs.
REQ-011 SHALL have port m_data_i  input  NUM_M*DW  master write data.
REQ-012 SHALL have port m_we_i  input  NUM_M  master write enables.
REQ-013 SHALL have port m_req_i  input  NUM_M  master requests.
REQ-014 SHALL have port m_data_o  output  NUM_M*DW  master read data.
REQ-015 SHALL have port m_ack_o  output  NUM_M  per-master completion pulse.
REQ-016 SHALL have port s_addr_o  output  AW  granted address, with the slave-select field zeroed.
REQ-017 SHALL have port s_data_o  output  DW  granted write data.
REQ-018 SHALL have port s_we_o  output  NUM_S  per-slave write enable.
REQ-019 SHALL have port s_req_o  output  NUM_S  per-slave request.
REQ-020 SHALL have port s_data_i  input  NUM_S*DW  slave read data.
REQ-021 SHALL have port s_ack_i  input  NUM_S  slave acks; combinational (same-cycle) acks are legal.
REQ-022 SHALL have port hold_flag_o  output  1  pipeline hold to the core.
REQ-023 SHALL have port err_o  output  1  error pulse (timeout or unmapped slave).

Function
REQ-024 SHALL implement a two-state FSM with states IDLE and ACCESS; a registered grant index g; a registered round-robin pointer rr; and a timeout counter tcnt (8 bit).
REQ-025 SHALL, in IDLE with any m_req_i set, register g as the winner and enter ACCESS on the next edge: mode 0 picks the lowest set index; mode 1 picks the first set index at or after rr, wrapping modulo NUM_M.
REQ-026 SHALL remain in IDLE and drive all s_req_o, s_we_o, m_ack_o and err_o to 0 while no m_req_i is set.
REQ-027 SHALL, in ACCESS, compute slave index s = m_addr_i[g][AW-1:AW-4] and broadcast the address and data of master g on s_addr_o and s_data_o.
REQ-028 SHALL, in ACCESS, assert s_req_o[s] = 1 and s_we_o[s] = m_we_i[g]; all other s_req_o and s_we_o bits SHALL be 0.
REQ-029 SHALL, in ACCESS with s_ack_i[s] = 1, drive m_ack_o[g] = 1 and m_data_o[g] = s_data_i[s] combinationally in that cycle, then return to IDLE.
REQ-030 SHALL drive m_data_o lanes of masters other than g to 0 whenever their m_ack_o bit is 0.
REQ-031 SHALL have a minimum latency of 1 cycle: request at cycle N, ack at cycle N+1 when the slave acks combinationally; back-to-back transfers SHALL have one IDLE cycle between them.
REQ-032 SHALL clear tcnt on entry to ACCESS and increment it each ACCESS cycle without an ack.
REQ-033 SHALL, when tcnt = TIMEOUT-1 without an ack, pulse m_ack_o[g] = 1, m_data_o[g] = 0 and err_o = 1 for one cycle, and return to IDLE.
REQ-034 SHALL, when s >= NUM_S (unmapped slave), assert no s_req_o and, in the first ACCESS cycle, pulse m_ack_o[g] = 1, m_data_o[g] = 0 and err_o = 1, then return to IDLE.
REQ-035 SHALL, if m_req_i[g] falls during ACCESS, abort to IDLE on the next edge with no m_ack_o and no err_o; an ack arriving in that same cycle SHALL be ignored.
REQ-036 SHALL, in mode 1, set rr = (g+1) mod NUM_M on every completion, timeout, unmapped error or abort; in mode 0 rr SHALL be unused.
REQ-037 SHALL drive hold_flag_o = 1 when in ACCESS with g != 0, or in IDLE with any m_req_i[NUM_M-1:1] set; otherwise 0.
REQ-038 SHALL ignore new requests arriving during ACCESS until the FSM returns to IDLE; no preemption.

Reset
REQ-039 SHALL, while rst = 1 at a clock edge, set state = IDLE, g = 0, rr = 0 and tcnt = 0.
REQ-040 SHALL hold m_ack_o, s_req_o, s_we_o, err_o and hold_flag_o at 0 while rst = 1, including when reset occurs mid-ACCESS, with no ack issued.

Verification
REQ-041 SHALL cover single read: m0 requests 0x1000_0004, slave 1 acks combinationally with 0xDEAD_BEEF -> s_req_o = 0x02 at cycle 1, m_ack_o[0] = 1 and m_data_o[0] = 0xDEAD_BEEF at cycle 1, FSM in IDLE at cycle 2.
REQ-042 SHALL cover fixed priority: m2 and m3 request simultaneously with ARB_MODE = 0 -> m2 served first, m3 served after one IDLE cycle, hold_flag_o = 1 throughout.
REQ-043 SHALL cover round-robin: all four masters hold requests with ARB_MODE = 1 -> grant order 0, 1, 2, 3, 0.
REQ-044 SHALL cover timeout: slave 3 never acks, TIMEOUT = 16 -> m_ack_o and err_o pulse 16 cycles after grant, with m_data_o = 0.
REQ-045 SHALL cover unmapped access: NUM_S = 8, address 0xF000_0000 -> no s_req_o asserted, err_o and m_ack_o pulse in the first ACCESS cycle.
REQ-046 SHALL cover reset mid-operation: rst asserted in the 3rd ACCESS cycle of a pending access -> all outputs 0, and the next request is granted normally after rst is released.
